// File: rtl/bus_master_if_if.sv
// rtl/bus_master_if_if.sv - core command and shared-bus signal bundle for bus_master_if
interface bus_master_if_if;
  logic        cpu_req;
  logic        cpu_rw;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic [31:0] cpu_rd_data;
  logic        busy;
  logic        ack;
  logic        err;
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;

  modport master (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wr_data, bus_grnt_, bus_rd_data, bus_rdy_,
    output cpu_rd_data, busy, ack, err, bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
  );

  modport slave (
    output cpu_req, cpu_rw, cpu_addr, cpu_wr_data, bus_grnt_, bus_rd_data, bus_rdy_,
    input  cpu_rd_data, busy, ack, err, bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
  );
endinterface

// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - single-word shared-bus initiator (request, grant, strobe, ready, release)
// Define BUS_TIMEOUT_EN to abort ACCESS with err after TIMEOUT_CYCLES cycles without bus_rdy_.
module bus_master_if #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic             clk,
  input logic             reset,
  bus_master_if_if.master bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("bus_master_if: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, REQ, ACCESS} state_t;

  state_t      state;
  logic        req_n_q;
  logic        as_n_q;
  logic        rw_q;
  logic [29:0] addr_q;
  logic [31:0] wr_data_q;
  logic [31:0] rd_data_q;
  logic        ack_q;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;
  logic       err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_n_q   <= 1'b1;
      as_n_q    <= 1'b1;
      rw_q      <= 1'b1;
      addr_q    <= 30'h0;
      wr_data_q <= 32'h0;
      rd_data_q <= 32'h0;
      ack_q     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt   <= 8'h0;
      err_q     <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        // Latching happens even in an ack cycle, so a follow-on command costs one IDLE cycle.
        IDLE: begin
          if (bus.cpu_req) begin
            addr_q    <= bus.cpu_addr;
            rw_q      <= bus.cpu_rw;
            wr_data_q <= bus.cpu_wr_data;
            req_n_q   <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (!bus.bus_grnt_) begin
            as_n_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt <= 8'h0;
`endif
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          // Strobe lasts only the first ACCESS cycle; grant is no longer looked at here.
          as_n_q <= 1'b1;
          if (!bus.bus_rdy_) begin
            if (rw_q) rd_data_q <= bus.bus_rd_data;
            ack_q   <= 1'b1;
            req_n_q <= 1'b1;
            state   <= IDLE;
          end
`ifdef BUS_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            err_q     <= 1'b1;
            rd_data_q <= 32'h0;
            req_n_q   <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE) || (bus.cpu_req && !ack_q);
  assign bus.ack         = ack_q;
  assign bus.cpu_rd_data = rd_data_q;
  assign bus.bus_req_    = req_n_q;
  assign bus.bus_as_     = as_n_q;
  assign bus.bus_rw      = rw_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_data = wr_data_q;
`ifdef BUS_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_if.sv
// tb/tb_bus_master_if.sv - randomized bench for bus_master_if against a cycle-timeline model
module tb_bus_master_if;
  localparam int TMO    = 8;
  localparam int P_NONE = 0;
  localparam int P_ACK  = 1;
  localparam int P_ERR  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_master_if_if bus ();
  bus_master_if #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          n_cmp;
  int          n_bad;
  int          pend;
  logic [31:0] pend_rd;
  logic [31:0] model_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outcome of the previous transaction is visible in the cycle after its terminating cycle.
  task automatic check_pending();
    if (pend == P_ACK) model_rd = pend_rd;
    else if (pend == P_ERR) model_rd = 32'h0;
    chk("ack", 64'(bus.ack), 64'(pend == P_ACK));
    chk("err", 64'(bus.err), 64'(pend == P_ERR));
    chk("rd_data", 64'(bus.cpu_rd_data), 64'(model_rd));
    pend = P_NONE;
  endtask

  task automatic idle_cycle();
    tick();
    bus.cpu_req     = 1'b0;
    bus.cpu_addr    = 30'($urandom);
    bus.bus_grnt_   = 1'b1;
    bus.bus_rdy_    = 1'b1;
    bus.bus_rd_data = $urandom;
    @(negedge clk);
    check_pending();
    chk("idle_busy", 64'(bus.busy), 64'(0));
    chk("idle_req_", 64'(bus.bus_req_), 64'(1));
    chk("idle_as_", 64'(bus.bus_as_), 64'(1));
  endtask

  // gd: REQ cycles before grant; rdly: ACCESS cycles before rdy_ (0 = in strobe cycle).
  task automatic run_txn(input bit rw, input logic [29:0] addr, input logic [31:0] wd,
                         input int gd, input int rdly, input bit early, input logic [31:0] rdat);
    int strobe_c, rdy_c, term_c, early_c;
    bit timed_out;
    bit busy0;
    strobe_c = 2 + gd;
`ifdef BUS_TIMEOUT_EN
    timed_out = (rdly >= TMO);
`else
    timed_out = 1'b0;
`endif
    rdy_c   = strobe_c + rdly;
    term_c  = timed_out ? strobe_c + TMO : rdy_c + 1;
    early_c = (early && gd > 0) ? 1 + int'($urandom_range(gd - 1)) : -1;
    for (int c = 0; c < term_c; c++) begin
      tick();
      if (c == 0) begin
        bus.cpu_req     = 1'b1;
        bus.cpu_rw      = rw;
        bus.cpu_addr    = addr;
        bus.cpu_wr_data = wd;
      end else begin
        bus.cpu_rw      = 1'($urandom);
        bus.cpu_addr    = 30'($urandom);
        bus.cpu_wr_data = $urandom;
      end
      if (c < 1 + gd) bus.bus_grnt_ = 1'b1;
      else if (c == 1 + gd) bus.bus_grnt_ = 1'b0;
      else bus.bus_grnt_ = 1'($urandom);
      bus.bus_rdy_    = !((c == rdy_c && !timed_out) || c == early_c);
      bus.bus_rd_data = (c == rdy_c) ? rdat : $urandom;
      @(negedge clk);
      if (c == 0) begin
        busy0 = (pend != P_ACK);
        check_pending();
        chk("busy0", 64'(bus.busy), 64'(busy0));
      end else begin
        chk("busy", 64'(bus.busy), 64'(1));
        chk("ack_lo", 64'(bus.ack), 64'(0));
        chk("err_lo", 64'(bus.err), 64'(0));
        chk("rd_hold", 64'(bus.cpu_rd_data), 64'(model_rd));
        chk("bus_addr", 64'(bus.bus_addr), 64'(addr));
        chk("bus_rw", 64'(bus.bus_rw), 64'(rw));
        chk("bus_wr_data", 64'(bus.bus_wr_data), 64'(wd));
      end
      chk("bus_req_", 64'(bus.bus_req_), 64'(c == 0));
      chk("bus_as_", 64'(bus.bus_as_), 64'(c != strobe_c));
    end
    pend    = timed_out ? P_ERR : P_ACK;
    pend_rd = rw ? rdat : model_rd;
  endtask

  task automatic reset_in_access();
    tick();
    bus.cpu_req   = 1'b1;
    bus.cpu_rw    = 1'b1;
    bus.cpu_addr  = 30'h55;
    bus.bus_grnt_ = 1'b1;
    bus.bus_rdy_  = 1'b1;
    tick();
    bus.bus_grnt_ = 1'b0;
    tick();
    bus.bus_grnt_ = 1'b1;
    @(negedge clk);
    chk("rst_pre_as_", 64'(bus.bus_as_), 64'(0));
    #2 reset = 1'b1;
    #1;
    chk("rst_async_req_", 64'(bus.bus_req_), 64'(1));
    chk("rst_async_as_", 64'(bus.bus_as_), 64'(1));
    bus.cpu_req = 1'b0;
    @(negedge clk);
    model_rd = 32'h0;
    pend     = P_NONE;
    chk("rst_ack", 64'(bus.ack), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_rd_data", 64'(bus.cpu_rd_data), 64'(0));
    reset = 1'b0;
  endtask

  initial begin
    int rdly;
    n_cmp    = 0;
    n_bad    = 0;
    pend     = P_NONE;
    pend_rd  = 32'h0;
    model_rd = 32'h0;
    bus.cpu_req     = 1'b0;
    bus.cpu_rw      = 1'b0;
    bus.cpu_addr    = 30'h0;
    bus.cpu_wr_data = 32'h0;
    bus.bus_grnt_   = 1'b1;
    bus.bus_rdy_    = 1'b1;
    bus.bus_rd_data = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_req_", 64'(bus.bus_req_), 64'(1));
    chk("reset_as_", 64'(bus.bus_as_), 64'(1));
    chk("reset_rw", 64'(bus.bus_rw), 64'(1));
    chk("reset_addr", 64'(bus.bus_addr), 64'(0));
    chk("reset_wr_data", 64'(bus.bus_wr_data), 64'(0));
    chk("reset_rd_data", 64'(bus.cpu_rd_data), 64'(0));
    chk("reset_ack", 64'(bus.ack), 64'(0));
    chk("reset_err", 64'(bus.err), 64'(0));
    chk("reset_busy", 64'(bus.busy), 64'(0));
    reset = 1'b0;

    run_txn(1'b1, 30'h3, 32'h0, 0, 1, 1'b0, 32'hDEADBEEF);
    idle_cycle();
    run_txn(1'b0, 30'h0000_0100, 32'h1234_5678, 5, 2, 1'b0, 32'hFFFF_FFFF);
    idle_cycle();
    run_txn(1'b1, 30'h10, 32'h0, 0, 0, 1'b0, 32'hA5A5_0001);
    run_txn(1'b0, 30'h20, 32'hCAFE_F00D, 1, 1, 1'b0, 32'h0);
    idle_cycle();
    run_txn(1'b1, 30'h44, 32'h0, 3, 3, 1'b1, 32'h0BAD_CAFE);
    idle_cycle();
`ifdef BUS_TIMEOUT_EN
    run_txn(1'b1, 30'h3FFF_FFF0, 32'h0, 0, TMO + 4, 1'b0, 32'h1111_1111);
    idle_cycle();
    run_txn(1'b1, 30'h3FFF_FFF0, 32'h0, 1, TMO - 1, 1'b0, 32'h2222_2222);
    idle_cycle();
`else
    run_txn(1'b1, 30'h3FFF_FFF0, 32'h0, 1, 12, 1'b0, 32'h2222_2222);
    idle_cycle();
`endif
    reset_in_access();
    run_txn(1'b1, 30'h77, 32'h0, 0, 0, 1'b0, 32'h7777_0077);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      rdly = ($urandom_range(7) == 0) ? 9 + int'($urandom_range(3)) : int'($urandom_range(5));
      run_txn(1'($urandom), 30'($urandom), $urandom, int'($urandom_range(6)), rdly,
              1'($urandom), $urandom);
      if ($urandom_range(1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
